// File: rtl/pwm_seg_display.sv
// pwm_seg_display
// Sequential binary-to-seven-segment driver for the PWM duty readout.
// A value accepted through the ready/load handshake is converted to BCD with
// shift-add-3 (one input bit per clock), then committed as DIGITS active-low
// segment patterns with leading-zero blanking, overflow dashes and an
// optional blink that blanks the whole display on alternate half-periods.
//
// Ports:
//   clk      : system clock, all logic on the rising edge
//   rst_n    : synchronous active-low reset
//   value    : unsigned binary value to display (sampled only on acceptance)
//   load     : request strobe, accepted only on an edge where ready=1
//   blink_en : 1 = blank display during the blink "off" phase
//   ready    : 1 = idle, next load accepted
//   done     : one-cycle pulse after the edge new digits are committed
//   ovf      : 1 = last committed value exceeded 10^DIGITS-1
//   seg      : active-low segments, digit i at [7i+6:7i], digit 0 = units,
//              per-digit bit order {g,f,e,d,c,b,a}
module pwm_seg_display #(
    parameter int DIGITS    = 3,
    parameter int IN_W      = 7,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IN_W-1:0]       value,
    input  logic                  load,
    input  logic                  blink_en,
    output logic                  ready,
    output logic                  done,
    output logic                  ovf,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int BW    = 4 * DIGITS;
    localparam int SW    = 7 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam int BL_W  = $clog2(BLINK_DIV);
    localparam logic [63:0]   MAX_VAL  = 64'(10 ** DIGITS - 1);
    localparam logic [6:0]    SEG_BLANK = 7'b1111111;
    localparam logic [6:0]    SEG_DASH  = 7'b0111111;
    // Digit 0 shows "0", every higher digit blank.
    localparam logic [SW-1:0] DISP_RST = ~(SW'(7'b0111111));

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [IN_W-1:0]  shift_r;
    logic [BW-1:0]    bcd_r;
    logic [BW-1:0]    bcd_adj_s;
    logic [CNT_W-1:0] cnt_r;
    logic             ovf_pend_r;
    logic [SW-1:0]    disp_r;
    logic [SW-1:0]    disp_enc_s;
    logic             ovf_r;
    logic             done_r;
    logic             ready_r;
    logic [BL_W-1:0]  blink_cnt_r;
    logic             phase_r;

    function automatic logic [6:0] seg7_enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Add 3 to every nibble that is 5 or more, ahead of the left shift.
    function automatic logic [BW-1:0] bcd_add3(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = b[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Scan from the most significant digit; zeros stay blank until the first
    // non-zero digit, digit 0 is always shown. Overflow overrides everything.
    function automatic logic [SW-1:0] encode_disp(input logic [BW-1:0] b,
                                                  input logic over);
        logic [SW-1:0] r;
        logic          lead;
        r    = {SW{1'b1}};
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (over) begin
                r[7*i +: 7] = SEG_DASH;
            end else if ((i > 0) && lead && (b[4*i +: 4] == 4'd0)) begin
                r[7*i +: 7] = SEG_BLANK;
            end else begin
                r[7*i +: 7] = seg7_enc(b[4*i +: 4]);
                lead        = 1'b0;
            end
        end
        return r;
    endfunction

    // Combinational helpers for the conversion step and the commit pattern.
    always_comb begin
        bcd_adj_s  = bcd_add3(bcd_r);
        disp_enc_s = encode_disp(bcd_r, ovf_pend_r);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load) begin
                    state_next_s = ST_CONVERT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CONVERT: begin
                // cnt_r counts remaining shifts; the last one happens now.
                if (cnt_r == CNT_W'(1)) begin
                    state_next_s = ST_COMMIT;
                end else begin
                    state_next_s = ST_CONVERT;
                end
            end
            ST_COMMIT: state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Conversion datapath, committed display and handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_r    <= '0;
            bcd_r      <= '0;
            cnt_r      <= '0;
            ovf_pend_r <= 1'b0;
            disp_r     <= DISP_RST;
            ovf_r      <= 1'b0;
            done_r     <= 1'b0;
            ready_r    <= 1'b1;
        end else begin
            done_r  <= (state_r == ST_COMMIT);
            ready_r <= (state_next_s == ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (load) begin
                        shift_r    <= value;
                        bcd_r      <= '0;
                        cnt_r      <= CNT_W'(IN_W);
                        ovf_pend_r <= (64'(value) > MAX_VAL);
                    end
                end
                ST_CONVERT: begin
                    {bcd_r, shift_r} <= {bcd_adj_s, shift_r} << 1'b1;
                    cnt_r            <= cnt_r - CNT_W'(1);
                end
                ST_COMMIT: begin
                    disp_r <= disp_enc_s;
                    ovf_r  <= ovf_pend_r;
                end
                default: begin
                    disp_r <= DISP_RST;
                end
            endcase
        end
    end

    // Free-running blink divider; phase flips each BLINK_DIV cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt_r <= '0;
            phase_r     <= 1'b0;
        end else if (blink_cnt_r == BL_W'(BLINK_DIV - 1)) begin
            blink_cnt_r <= '0;
            phase_r     <= ~phase_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + BL_W'(1);
        end
    end

    // Blink masks the output only; the committed pattern is left untouched.
    always_comb begin
        seg = disp_r;
        if (blink_en && phase_r) begin
            seg = {SW{1'b1}};
        end else begin
            seg = disp_r;
        end
    end

    assign ready = ready_r;
    assign done  = done_r;
    assign ovf   = ovf_r;

endmodule

// File: tb/tb_pwm_seg_display.sv
// Bench for pwm_seg_display: a 3-digit and a 2-digit instance share one
// stimulus stream. A decimal-arithmetic model predicts every output each
// cycle; literal expectations pin the key cases.
module tb_pwm_seg_display;

    localparam int IN_W = 7;
    localparam int BDIV = 4;
    localparam logic [20:0] RST3 = {7'b1111111, 7'b1111111, 7'b1000000};
    localparam logic [20:0] D42  = {7'b1111111, 7'b0011001, 7'b0100100};

    logic            clk = 1'b0;
    logic            rst_n, load, blink_en;
    logic [IN_W-1:0] value;
    logic            ready3, done3, ovf3, ready2, done2, ovf2;
    logic [20:0]     seg3;
    logic [13:0]     seg2;

    always #5 clk = ~clk;

    pwm_seg_display #(.DIGITS(3), .IN_W(IN_W), .BLINK_DIV(BDIV)) dut3 (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load),
        .blink_en(blink_en), .ready(ready3), .done(done3), .ovf(ovf3),
        .seg(seg3));

    pwm_seg_display #(.DIGITS(2), .IN_W(IN_W), .BLINK_DIV(BDIV)) dut2 (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load),
        .blink_en(blink_en), .ready(ready2), .done(done2), .ovf(ovf2),
        .seg(seg2));

    int tests = 0;
    int fails = 0;

    // model state
    int          cyc = 0;
    bit          mvalid = 1'b0;
    bit          busy = 1'b0;
    int          commit_at = 0;
    int          pend = 0;
    int          rst_cyc = 0;
    logic [20:0] disp3_m;
    logic [13:0] disp2_m;
    bit          ovf3_m, ovf2_m, done_m;
    int          done3_cnt = 0;

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Display of v on nd digits, straight from the decimal rules.
    function automatic logic [41:0] expect_disp(input int v, input int nd);
        logic [41:0] r;
        r = '1;
        for (int i = 0; i < nd; i++) begin
            if (v > 10 ** nd - 1)
                r[7*i +: 7] = 7'b0111111;
            else if (i > 0 && v < 10 ** i)
                r[7*i +: 7] = 7'b1111111;
            else
                r[7*i +: 7] = pat((v / (10 ** i)) % 10);
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: sample inputs applied at the edge, advance model, compare.
    task automatic tick();
        bit          r_s, l_s;
        int          v_s;
        logic [41:0] tmp;
        logic [20:0] e3;
        logic [13:0] e2;
        bit          ph;
        r_s = rst_n;
        l_s = load;
        v_s = int'(value);
        @(posedge clk);
        #1;
        cyc++;
        if (!r_s) begin
            mvalid  = 1'b1;
            busy    = 1'b0;
            disp3_m = RST3;
            disp2_m = RST3[13:0];
            ovf3_m  = 1'b0;
            ovf2_m  = 1'b0;
            done_m  = 1'b0;
            rst_cyc = cyc;
        end else if (mvalid) begin
            done_m = 1'b0;
            if (busy && cyc == commit_at) begin
                tmp     = expect_disp(pend, 3);
                disp3_m = tmp[20:0];
                tmp     = expect_disp(pend, 2);
                disp2_m = tmp[13:0];
                ovf3_m  = (pend > 999);
                ovf2_m  = (pend > 99);
                done_m  = 1'b1;
                busy    = 1'b0;
            end else if (!busy && l_s) begin
                busy      = 1'b1;
                pend      = v_s;
                commit_at = cyc + IN_W + 1;
            end
        end
        if (mvalid) begin
            ph = (((cyc - rst_cyc) / BDIV) % 2) == 1;
            e3 = (blink_en && ph) ? '1 : disp3_m;
            e2 = (blink_en && ph) ? '1 : disp2_m;
            check("ready3", 64'(ready3), 64'(!busy));
            check("ready2", 64'(ready2), 64'(!busy));
            check("done3", 64'(done3), 64'(done_m));
            check("done2", 64'(done2), 64'(done_m));
            check("ovf3", 64'(ovf3), 64'(ovf3_m));
            check("ovf2", 64'(ovf2), 64'(ovf2_m));
            check("seg3", 64'(seg3), 64'(e3));
            check("seg2", 64'(seg2), 64'(e2));
        end
        if (done3) done3_cnt++;
    endtask

    task automatic run_conv(input int v);
        value = IN_W'(v);
        load  = 1'b1;
        tick();
        load = 1'b0;
        repeat (IN_W + 2) tick();
    endtask

    int          done_at;
    int          offs;
    bit          found;
    int          dv[3];
    logic [20:0] de[3];

    initial begin
        dv = '{5, 0, 70};
        de = '{{7'b1111111, 7'b1111111, 7'b0010010},
               {7'b1111111, 7'b1111111, 7'b1000000},
               {7'b1111111, 7'b1111000, 7'b1000000}};
        rst_n = 1'b0; load = 1'b0; value = '0; blink_en = 1'b0;
        tick(); tick();
        check("reset_seg3", 64'(seg3), 64'(RST3));
        check("reset_ready3", 64'(ready3), 64'd1);
        rst_n = 1'b1;
        tick();

        // value 100: done on E8, "100" on 3 digits, dashes on 2 digits
        done_at = -1;
        value = 7'd100; load = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (done3 && done_at < 0) done_at = k;
            if (k == 7) check("ready_low_e7", 64'(ready3), 64'd0);
            if (k == 8) check("ready_high_e8", 64'(ready3), 64'd1);
        end
        check("done_latency", 64'(done_at), 64'd8);
        check("seg3_100", 64'(seg3), 64'({7'b1111001, 7'b1000000, 7'b1000000}));
        check("seg2_100", 64'(seg2), 64'({7'b0111111, 7'b0111111}));
        check("ovf2_100", 64'(ovf2), 64'd1);
        check("ovf3_100", 64'(ovf3), 64'd0);

        run_conv(99);
        check("seg2_99", 64'(seg2), 64'({7'b0010000, 7'b0010000}));
        check("ovf2_99", 64'(ovf2), 64'd0);

        for (int i = 0; i < 3; i++) begin
            run_conv(dv[i]);
            check("seg3_table", 64'(seg3), 64'(de[i]));
        end

        // load 42, then a second load of 7 on E3 while busy is ignored
        done3_cnt = 0;
        value = 7'd42; load = 1'b1;
        tick();
        load = 1'b0;
        tick(); tick();
        value = 7'd7; load = 1'b1;
        tick();
        load = 1'b0;
        repeat (10) tick();
        check("busy_load_done_cnt", 64'(done3_cnt), 64'd1);
        check("seg3_42", 64'(seg3), 64'(D42));

        // blink: 8 of any 16 consecutive cycles are blank
        blink_en = 1'b1;
        offs = 0;
        repeat (16) begin
            tick();
            if (seg3 === 21'h1fffff) offs++;
        end
        check("blink_off_count", 64'(offs), 64'd8);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (seg3 === 21'h1fffff) found = 1'b1;
            else tick();
        end
        check("blink_off_seen", 64'(found), 64'd1);
        blink_en = 1'b0;
        #1;
        check("blink_en_immediate", 64'(seg3), 64'(D42));
        tick();

        // reset on E4 of a conversion aborts it
        run_conv(120);
        check("ovf2_120", 64'(ovf2), 64'd1);
        value = 7'd55; load = 1'b1;
        tick();
        load = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        done3_cnt = 0;
        repeat (12) tick();
        check("abort_no_done", 64'(done3_cnt), 64'd0);
        check("abort_seg3", 64'(seg3), 64'(RST3));
        check("abort_ovf2", 64'(ovf2), 64'd0);
        check("abort_ready", 64'(ready3), 64'd1);

        // reset and load together: reset wins
        rst_n = 1'b0; load = 1'b1; value = 7'd9;
        tick();
        rst_n = 1'b1; load = 1'b0;
        tick();
        check("rst_load_ready", 64'(ready3), 64'd1);
        check("rst_load_seg3", 64'(seg3), 64'(RST3));

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 149) != 0);
            load  = ($urandom_range(0, 2) == 0);
            value = IN_W'($urandom_range(0, 127));
            if ($urandom_range(0, 15) == 0) blink_en = ~blink_en;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
